// File: rtl/decimator_mc.sv
// ---------------------------------------------------------------------------
// decimator_mc
//
// Purpose:
//   Multi-channel, single-clock decimator sitting between the integrator and
//   comb sections of a CIC chain. One sample in every R accepted samples is
//   kept and announced with a one-cycle out_valid strobe. All channels share
//   one decimation phase. R is picked up from rate_i only at frame starts.
//   No derived clock is produced; downstream logic uses out_valid as an
//   enable.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous, active-low reset
//   rate_i     requested decimation rate (legal range 1..MAX_RATE)
//   clr        synchronous frame restart; wins over in_valid
//   in_valid   in_data carries a sample this cycle
//   in_data    packed samples, channel k at [k*WIDTH +: WIDTH]
//   out_valid  one-cycle strobe marking a new decimated sample
//   out_data   captured samples, same packing, held between strobes
//   rate_err   sticky flag, set when an illegal rate is sampled
// ---------------------------------------------------------------------------
module decimator_mc #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 1,
  parameter int MAX_RATE = 64,
  parameter int RATE_W   = $clog2(MAX_RATE + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [RATE_W-1:0]         rate_i,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      rate_err
);

  localparam int                DW    = CHANNELS * WIDTH;
  localparam logic [RATE_W-1:0] MAX_R = RATE_W'(MAX_RATE);
  localparam logic [RATE_W-1:0] ONE   = RATE_W'(1);

  logic [RATE_W-1:0] r_cnt;
  logic [RATE_W-1:0] r_rate_q;
  logic              r_out_valid;
  logic [DW-1:0]     r_out_data;
  logic              r_rate_err;

  logic [RATE_W-1:0] w_rate_san;
  logic              w_rate_bad;
  logic [RATE_W-1:0] w_cnt_last;
  logic              w_frame_start;

  // Clamp the requested rate into 1..MAX_RATE; an out-of-range request is
  // still usable but is flagged so software can notice the misconfiguration.
  always_comb begin
    w_rate_san = rate_i;
    w_rate_bad = 1'b0;
    if (rate_i == '0) begin
      w_rate_san = ONE;
      w_rate_bad = 1'b1;
    end else if (rate_i > MAX_R) begin
      w_rate_san = MAX_R;
      w_rate_bad = 1'b1;
    end
  end

  // Last phase of the active frame; rate_q is never 0 so this cannot wrap.
  assign w_cnt_last    = r_rate_q - ONE;
  assign w_frame_start = (r_cnt == '0);

  // Phase counter, active rate, capture register and sticky error.
  // clr takes priority over a coincident sample, which is simply dropped.
  // Idle cycles hold all state so gaps never advance the phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_rate_q    <= MAX_R;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_rate_err  <= 1'b0;
    end else if (clr) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      if (w_frame_start) begin
        r_rate_q    <= w_rate_san;
        r_out_data  <= in_data;
        r_out_valid <= 1'b1;
        // With R=1 every sample is a frame start, so the phase stays at 0.
        r_cnt       <= (w_rate_san == ONE) ? '0 : ONE;
        if (w_rate_bad) begin
          r_rate_err <= 1'b1;
        end
      end else begin
        r_out_valid <= 1'b0;
        r_cnt       <= (r_cnt == w_cnt_last) ? '0 : r_cnt + ONE;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign rate_err  = r_rate_err;

endmodule
